apb_access_scheduler: RTL and testbench
=======================================

Name:
apb_access_scheduler

Overview:
- Shares the bridge's single APB master between the AXI write front end and the AXI read front end, one transaction at a time, with round-robin arbitration.
- Sequences each granted burst into len+1 single APB accesses, generating addresses and counting beats.
- Returns per-beat read data/response to the read front end and a single accumulated write response to the write front end.

Parameters:
ADDR_WIDTH, 32, APB/AXI address width
DATA_WIDTH, 32, data width; INCR stride = DATA_WIDTH/8 bytes

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wr_req  in  1  write burst pending; held with wr_desc until wr_done
wr_desc  in  desc_t  write descriptor {addr, len[3:0], burst[1:0]}
wr_dvalid  in  1  write beat data available
wr_data  in  DATA_WIDTH  write beat data
wr_dready  out  1  write beat accepted
wr_done  out  1  one-cycle write completion pulse
wr_resp  out  2  write response, valid with wr_done
rd_req  in  1  read burst pending; held with rd_desc until last beat accepted
rd_desc  in  desc_t  read descriptor
rd_dvalid  out  1  read beat valid
rd_data  out  DATA_WIDTH  read beat data
rd_dresp  out  2  read beat response
rd_dlast  out  1  final read beat
rd_dready  in  1  read beat accepted
apb_start  out  1  one-cycle pulse launching one APB access
apb_write  out  1  access direction, stable until apb_done
apb_addr  out  ADDR_WIDTH  access address, stable until apb_done
apb_wdata  out  DATA_WIDTH  access write data, stable until apb_done
apb_done  in  1  one-cycle pulse: access finished
apb_rdata  in  DATA_WIDTH  read data, valid with apb_done
apb_slverr  in  1  access error, valid with apb_done

Behaviour:
- **Reset:** all outputs 0. State IDLE, beat counter 0, last_grant=READ. A reset mid-burst abandons the burst; the APB master shares rst_n.
- **States:** IDLE, W_DATA, W_APB, W_RESP, R_APB, R_DATA.
- **IDLE arbitration:** a single request is granted. If both request, grant the side opposite last_grant. Latch the descriptor, clear the beat counter and err flag, update last_grant. Next state is W_DATA or R_APB (one cycle of grant latency).
- **W_DATA:** wr_dready=1. On wr_dvalid, latch wr_data and go to W_APB.
- **W_APB:** apb_start=1 only in the first cycle. On apb_done, err |= apb_slverr. If beat==len go to W_RESP; otherwise advance the address, beat++, and go to W_DATA.
- **W_RESP:** wr_done=1 for one cycle; wr_resp = 2'b10 (SLVERR) if err else 2'b00 (OKAY); then IDLE. The requester must deassert wr_req in the following cycle.
- **R_APB:** apb_write=0, apb_start on the first cycle. On apb_done, register apb_rdata and the response (SLVERR if apb_slverr) and go to R_DATA.
- **R_DATA:** rd_dvalid=1 with data/resp held stable; rd_dlast = (beat==len). On rd_dready: if last, go to IDLE; else advance the address, beat++, and go to R_APB.
- **Address generation:** INCR adds DATA_WIDTH/8, modulo 2^ADDR_WIDTH. FIXED keeps the address.
- **WRAP/reserved burst:**
  - No APB access is issued.
  - Write: accept all len+1 data beats, then wr_done with SLVERR.
  - Read: return len+1 beats with data 0 and SLVERR.
- **Backpressure:** no new apb_start while a read beat is stalled or write data is absent.
- **Done cycles:** requests arriving during W_RESP or R_DATA are not sampled until IDLE.

Optional Feature:
- BRIDGE_SCHED_STRICT_PRIO_EN defined: write always wins ties; last_grant is unused.
- Undefined: round-robin as above.

Decomposition:
- bridge_utils package holds:
  - desc_t
  - BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - the sched state enum
- One natural sub-module: sched_addr_gen (address register, stride/burst rule, beat counter, last-beat flag).

Test Plan:
- Write INCR addr 0x1000 len=3, data A0..A3, no errors -> apb_addr 0x1000/0x1004/0x1008/0x100C, apb_write=1, one wr_done with OKAY.
- Read FIXED addr 0x20 len=1, apb_rdata 0x55 then 0x66 with slverr on beat 1 -> apb_addr 0x20 both; beats 0x55/OKAY then 0x66/SLVERR with rd_dlast.
- Both requests together twice:
  - Without the macro: write then read, then read then write.
  - With BRIDGE_SCHED_STRICT_PRIO_EN: write first both times.
- Write WRAP len=2 -> three wr_dready handshakes, no apb_start, wr_done with SLVERR.
- Read INCR addr 0xFFFFFFFC len=1 with rd_dready low 5 cycles -> beat held stable, no apb_start while stalled, second apb_addr 0x0.
- rst_n low during W_APB of beat 2 -> outputs 0, IDLE; a following read completes normally, and a tie then goes to write.

Source files
------------

// File: rtl/apb_access_scheduler_pkg.sv
// Shared types and constants for the APB access scheduler (package bridge_utils).
package bridge_utils;

   localparam int unsigned DESC_ADDR_WIDTH = 32;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef struct packed {
      logic [DESC_ADDR_WIDTH-1:0] addr;
      logic [3:0]                 len;
      logic [1:0]                 burst;
   } desc_t;

   typedef enum logic [2:0] {
      StIdle,
      StWData,
      StWApb,
      StWResp,
      StRApb,
      StRData
   } sched_state_e;

   typedef enum logic {
      GrantWrite,
      GrantRead
   } grant_e;

   // Only FIXED and INCR bursts become real APB accesses.
   function automatic logic burst_supported(input logic [1:0] burst);
      return (burst == BURST_FIXED) || (burst == BURST_INCR);
   endfunction

endpackage

// File: rtl/apb_access_scheduler_if.sv
// Bundle of write front end, read front end and APB master handshakes around the scheduler.
interface apb_access_scheduler_if
   import bridge_utils::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  wr_req;
   desc_t                 wr_desc;
   logic                  wr_dvalid;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_dready;
   logic                  wr_done;
   logic [1:0]            wr_resp;

   logic                  rd_req;
   desc_t                 rd_desc;
   logic                  rd_dvalid;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [1:0]            rd_dresp;
   logic                  rd_dlast;
   logic                  rd_dready;

   logic                  apb_start;
   logic                  apb_write;
   logic [ADDR_WIDTH-1:0] apb_addr;
   logic [DATA_WIDTH-1:0] apb_wdata;
   logic                  apb_done;
   logic [DATA_WIDTH-1:0] apb_rdata;
   logic                  apb_slverr;

   modport master (
      input  wr_req, wr_desc, wr_dvalid, wr_data,
      input  rd_req, rd_desc, rd_dready,
      input  apb_done, apb_rdata, apb_slverr,
      output wr_dready, wr_done, wr_resp,
      output rd_dvalid, rd_data, rd_dresp, rd_dlast,
      output apb_start, apb_write, apb_addr, apb_wdata
   );

   modport slave (
      output wr_req, wr_desc, wr_dvalid, wr_data,
      output rd_req, rd_desc, rd_dready,
      output apb_done, apb_rdata, apb_slverr,
      input  wr_dready, wr_done, wr_resp,
      input  rd_dvalid, rd_data, rd_dresp, rd_dlast,
      input  apb_start, apb_write, apb_addr, apb_wdata
   );

endinterface

// File: rtl/apb_access_scheduler_sched_addr_gen.sv
// Burst address register and beat counter: INCR steps by the bus width, FIXED and others hold.
module sched_addr_gen
   import bridge_utils::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_load,
   input  desc_t                 i_desc,
   input  logic                  i_advance,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic                  o_last
);
   localparam logic [ADDR_WIDTH-1:0] Stride = ADDR_WIDTH'(DATA_WIDTH / 8);

   logic [ADDR_WIDTH-1:0] r_addr;
   logic [3:0]            r_beat;
   logic [3:0]            r_len;
   logic [1:0]            r_burst;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr  <= '0;
         r_beat  <= '0;
         r_len   <= '0;
         r_burst <= BURST_FIXED;
      end else if (i_load) begin
         r_addr  <= ADDR_WIDTH'(i_desc.addr);
         r_beat  <= '0;
         r_len   <= i_desc.len;
         r_burst <= i_desc.burst;
      end else if (i_advance) begin
         // Wraps modulo 2^ADDR_WIDTH by natural overflow.
         if (r_burst == BURST_INCR) r_addr <= r_addr + Stride;
         r_beat <= r_beat + 4'd1;
      end
   end

   assign o_addr = r_addr;
   assign o_last = (r_beat == r_len);

endmodule

// File: rtl/apb_access_scheduler.sv
// Round-robin sharing of one APB master between write and read burst front ends.
// Define BRIDGE_SCHED_STRICT_PRIO_EN to make writes always win ties.
module apb_access_scheduler
   import bridge_utils::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   apb_access_scheduler_if.master bus
);
   sched_state_e          r_state;
   logic                  r_bad;
   logic                  r_err;
   logic                  r_wr_dready;
   logic                  r_wr_done;
   logic [1:0]            r_wr_resp;
   logic                  r_rd_dvalid;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic [1:0]            r_rd_dresp;
   logic                  r_rd_dlast;
   logic                  r_apb_start;
   logic                  r_apb_write;
   logic [DATA_WIDTH-1:0] r_apb_wdata;

   logic                  w_grant_wr;
   logic                  w_load;
   logic                  w_advance;
   desc_t                 w_desc;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic                  w_last;

`ifdef BRIDGE_SCHED_STRICT_PRIO_EN
   assign w_grant_wr = bus.wr_req;
`else
   grant_e r_last_grant;

   assign w_grant_wr = bus.wr_req && (!bus.rd_req || (r_last_grant == GrantRead));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant <= GrantRead;
      end else if (w_load) begin
         r_last_grant <= w_grant_wr ? GrantWrite : GrantRead;
      end
   end
`endif

   assign w_load    = (r_state == StIdle) && (bus.wr_req || bus.rd_req);
   assign w_desc    = w_grant_wr ? bus.wr_desc : bus.rd_desc;
   assign w_advance = !w_last &&
                      (((r_state == StWApb) && bus.apb_done) ||
                       ((r_state == StWData) && r_bad && bus.wr_dvalid) ||
                       ((r_state == StRData) && bus.rd_dready));

   sched_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_addr_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_load    (w_load),
      .i_desc    (w_desc),
      .i_advance (w_advance),
      .o_addr    (w_addr),
      .o_last    (w_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StIdle;
         r_bad       <= 1'b0;
         r_err       <= 1'b0;
         r_wr_dready <= 1'b0;
         r_wr_done   <= 1'b0;
         r_wr_resp   <= RESP_OKAY;
         r_rd_dvalid <= 1'b0;
         r_rd_data   <= '0;
         r_rd_dresp  <= RESP_OKAY;
         r_rd_dlast  <= 1'b0;
         r_apb_start <= 1'b0;
         r_apb_write <= 1'b0;
         r_apb_wdata <= '0;
      end else begin
         r_apb_start <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_grant_wr) begin
                  r_state     <= StWData;
                  r_bad       <= !burst_supported(bus.wr_desc.burst);
                  r_err       <= 1'b0;
                  r_wr_dready <= 1'b1;
               end else if (bus.rd_req) begin
                  r_state     <= StRApb;
                  r_bad       <= !burst_supported(bus.rd_desc.burst);
                  r_err       <= 1'b0;
                  r_apb_write <= 1'b0;
                  r_apb_start <= burst_supported(bus.rd_desc.burst);
               end
            end
            StWData: begin
               if (bus.wr_dvalid) begin
                  r_apb_wdata <= bus.wr_data;
                  if (!r_bad) begin
                     r_wr_dready <= 1'b0;
                     r_apb_write <= 1'b1;
                     r_apb_start <= 1'b1;
                     r_state     <= StWApb;
                  end else if (w_last) begin
                     // Unsupported burst: drain all beats, then report SLVERR.
                     r_wr_dready <= 1'b0;
                     r_wr_done   <= 1'b1;
                     r_wr_resp   <= RESP_SLVERR;
                     r_state     <= StWResp;
                  end
               end
            end
            StWApb: begin
               if (bus.apb_done) begin
                  r_err <= r_err | bus.apb_slverr;
                  if (w_last) begin
                     r_wr_done <= 1'b1;
                     r_wr_resp <= (r_err | bus.apb_slverr) ? RESP_SLVERR : RESP_OKAY;
                     r_state   <= StWResp;
                  end else begin
                     r_wr_dready <= 1'b1;
                     r_state     <= StWData;
                  end
               end
            end
            StWResp: begin
               r_wr_done <= 1'b0;
               r_state   <= StIdle;
            end
            StRApb: begin
               if (r_bad || bus.apb_done) begin
                  r_rd_data   <= r_bad ? '0 : bus.apb_rdata;
                  r_rd_dresp  <= (r_bad || bus.apb_slverr) ? RESP_SLVERR : RESP_OKAY;
                  r_rd_dvalid <= 1'b1;
                  r_rd_dlast  <= w_last;
                  r_state     <= StRData;
               end
            end
            StRData: begin
               if (bus.rd_dready) begin
                  r_rd_dvalid <= 1'b0;
                  r_rd_dlast  <= 1'b0;
                  if (r_rd_dlast) begin
                     r_state <= StIdle;
                  end else begin
                     r_apb_start <= !r_bad;
                     r_state     <= StRApb;
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign bus.wr_dready = r_wr_dready;
   assign bus.wr_done   = r_wr_done;
   assign bus.wr_resp   = r_wr_resp;
   assign bus.rd_dvalid = r_rd_dvalid;
   assign bus.rd_data   = r_rd_data;
   assign bus.rd_dresp  = r_rd_dresp;
   assign bus.rd_dlast  = r_rd_dlast;
   assign bus.apb_start = r_apb_start;
   assign bus.apb_write = r_apb_write;
   assign bus.apb_addr  = w_addr;
   assign bus.apb_wdata = r_apb_wdata;

endmodule

// File: tb/tb_apb_access_scheduler.sv
// Directed self-checking bench for apb_access_scheduler with a small APB responder model.
module tb_apb_access_scheduler;
   import bridge_utils::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   apb_access_scheduler_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   apb_access_scheduler #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   int          n_starts;
   int          n_whs;
   int          n_wdone;
   logic [31:0] log_addr  [16];
   logic [31:0] log_wdata [16];
   logic        log_write [16];
   logic [31:0] rsp_data  [8];
   logic        rsp_err   [8];

   logic [31:0] got_data [16];
   logic [1:0]  got_resp [16];
   logic        got_last [16];
   int          stall_bad;
   int          stall_s0;
   int          stall_s1;

   // APB slave: logs each access and completes it three cycles after the start pulse.
   always begin : apb_slave
      int idx;
      @(posedge clk);
      #1;
      if (rst_n && bus.apb_start) begin
         idx = n_starts;
         log_addr[idx % 16]  = bus.apb_addr;
         log_wdata[idx % 16] = bus.apb_wdata;
         log_write[idx % 16] = bus.apb_write;
         n_starts++;
         for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
         end
         if (rst_n) begin
            bus.apb_done   = 1'b1;
            bus.apb_rdata  = rsp_data[idx % 8];
            bus.apb_slverr = rsp_err[idx % 8];
            @(posedge clk);
            #1;
            bus.apb_done   = 1'b0;
            bus.apb_slverr = 1'b0;
         end
      end
   end

   always @(posedge clk) begin
      if (rst_n && bus.wr_dready && bus.wr_dvalid) n_whs++;
      if (rst_n && bus.wr_done) n_wdone++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end

   function automatic desc_t mk_desc(input logic [31:0] a, input logic [3:0] l,
                                     input logic [1:0] b);
      desc_t d;
      d.addr  = a;
      d.len   = l;
      d.burst = b;
      return d;
   endfunction

   task automatic clear_log();
      n_starts = 0;
      n_whs    = 0;
      n_wdone  = 0;
      for (int i = 0; i < 8; i++) begin
         rsp_data[i] = 32'h0;
         rsp_err[i]  = 1'b0;
      end
   endtask

   task automatic do_write(input desc_t d, input logic [31:0] base, output logic [1:0] resp,
                           output bit ok);
      int k;
      ok   = 1'b1;
      resp = 2'b11;
      bus.wr_desc = d;
      bus.wr_req  = 1'b1;
      for (int b = 0; b <= int'(d.len); b++) begin
         bus.wr_data   = base + 32'(b);
         bus.wr_dvalid = 1'b1;
         for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.wr_dready) break;
         end
         if (k == 300) begin
            ok = 1'b0;
            break;
         end
         @(posedge clk);
         #1;
         bus.wr_dvalid = 1'b0;
      end
      if (ok) begin
         for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.wr_done) break;
         end
         if (k == 300) ok = 1'b0;
         else begin
            resp = bus.wr_resp;
            @(posedge clk);
            #1;
         end
      end
      bus.wr_req    = 1'b0;
      bus.wr_dvalid = 1'b0;
   endtask

   task automatic do_read(input desc_t d, input int stall_beat, input int stall_cyc,
                          output bit ok);
      int k;
      ok = 1'b1;
      bus.rd_desc = d;
      bus.rd_req  = 1'b1;
      for (int b = 0; b <= int'(d.len); b++) begin
         for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.rd_dvalid) break;
         end
         if (k == 300) begin
            ok = 1'b0;
            break;
         end
         got_data[b] = bus.rd_data;
         got_resp[b] = bus.rd_dresp;
         got_last[b] = bus.rd_dlast;
         if (b == stall_beat) begin
            stall_s0 = n_starts;
            repeat (stall_cyc) begin
               @(negedge clk);
               if (!bus.rd_dvalid || bus.rd_data !== got_data[b] ||
                   bus.rd_dresp !== got_resp[b] || bus.rd_dlast !== got_last[b]) stall_bad++;
            end
            stall_s1 = n_starts;
         end
         bus.rd_dready = 1'b1;
         @(posedge clk);
         #1;
         bus.rd_dready = 1'b0;
      end
      bus.rd_req = 1'b0;
   endtask

   task automatic test_reset();
      bus.wr_req = 1'b0; bus.wr_desc = '0; bus.wr_dvalid = 1'b0; bus.wr_data = '0;
      bus.rd_req = 1'b0; bus.rd_desc = '0; bus.rd_dready = 1'b0;
      bus.apb_done = 1'b0; bus.apb_rdata = '0; bus.apb_slverr = 1'b0;
      clear_log();
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({bus.wr_dready, bus.wr_done, bus.wr_resp, bus.rd_dvalid, bus.rd_dresp, bus.rd_dlast,
           bus.apb_start, bus.apb_write} !== 10'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b required 0", {bus.wr_dready, bus.wr_done,
                  bus.wr_resp, bus.rd_dvalid, bus.rd_dresp, bus.rd_dlast, bus.apb_start,
                  bus.apb_write});
      end
      n_tests++;
      if ({bus.rd_data, bus.apb_addr, bus.apb_wdata} !== 96'b0) begin
         n_fail++;
         $display("FAIL reset_data: got %h required 0", {bus.rd_data, bus.apb_addr,
                  bus.apb_wdata});
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write_incr();
      logic [1:0] resp;
      bit ok;
      clear_log();
      do_write(mk_desc(32'h1000, 4'd3, BURST_INCR), 32'hA0, resp, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL wincr_done: timed out, required completion"); end
      n_tests++;
      if (n_starts !== 4) begin n_fail++; $display("FAIL wincr_starts: got %0d required 4", n_starts); end
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (log_addr[i] !== 32'h1000 + 32'(4 * i) || log_write[i] !== 1'b1 ||
             log_wdata[i] !== 32'hA0 + 32'(i)) begin
            n_fail++;
            $display("FAIL wincr_beat%0d: got addr %h wr %b data %h required %h 1 %h", i,
                     log_addr[i], log_write[i], log_wdata[i], 32'h1000 + 32'(4 * i),
                     32'hA0 + 32'(i));
         end
      end
      n_tests++;
      if (resp !== RESP_OKAY || n_wdone !== 1) begin
         n_fail++;
         $display("FAIL wincr_resp: got resp %b dones %0d required 00 1", resp, n_wdone);
      end
   endtask

   task automatic test_read_fixed();
      bit ok;
      clear_log();
      rsp_data[0] = 32'h55; rsp_err[0] = 1'b0;
      rsp_data[1] = 32'h66; rsp_err[1] = 1'b1;
      do_read(mk_desc(32'h20, 4'd1, BURST_FIXED), -1, 0, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL rfix_done: timed out, required completion"); end
      n_tests++;
      if (n_starts !== 2 || log_addr[0] !== 32'h20 || log_addr[1] !== 32'h20 ||
          log_write[0] !== 1'b0 || log_write[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL rfix_apb: got n %0d addr %h %h wr %b%b required 2 20 20 00", n_starts,
                  log_addr[0], log_addr[1], log_write[0], log_write[1]);
      end
      n_tests++;
      if (got_data[0] !== 32'h55 || got_resp[0] !== RESP_OKAY || got_last[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL rfix_beat0: got %h %b %b required 55 00 0", got_data[0], got_resp[0],
                  got_last[0]);
      end
      n_tests++;
      if (got_data[1] !== 32'h66 || got_resp[1] !== RESP_SLVERR || got_last[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL rfix_beat1: got %h %b %b required 66 10 1", got_data[1], got_resp[1],
                  got_last[1]);
      end
   endtask

   task automatic test_tie();
      logic [1:0] resp;
      bit ok_w;
      bit ok_r;
      logic first_exp;
      clear_log();
      fork
         do_write(mk_desc(32'h300, 4'd1, BURST_INCR), 32'hB0, resp, ok_w);
         do_read(mk_desc(32'h400, 4'd1, BURST_INCR), -1, 0, ok_r);
      join
      n_tests++;
      if (!ok_w || !ok_r || n_starts !== 4 || log_write[0] !== 1'b1 || log_write[3] !== 1'b0) begin
         n_fail++;
         $display("FAIL tie1_order: got ok %b%b n %0d first %b last %b required 11 4 1 0",
                  ok_w, ok_r, n_starts, log_write[0], log_write[3]);
      end
      // A lone write leaves the write side as the most recent grant.
      do_write(mk_desc(32'h380, 4'd0, BURST_INCR), 32'hC0, resp, ok_w);
      clear_log();
      fork
         do_write(mk_desc(32'h300, 4'd1, BURST_INCR), 32'hD0, resp, ok_w);
         do_read(mk_desc(32'h400, 4'd1, BURST_INCR), -1, 0, ok_r);
      join
`ifdef BRIDGE_SCHED_STRICT_PRIO_EN
      first_exp = 1'b1;
`else
      first_exp = 1'b0;
`endif
      n_tests++;
      if (!ok_w || !ok_r || n_starts !== 4 || log_write[0] !== first_exp ||
          log_write[3] !== !first_exp) begin
         n_fail++;
         $display("FAIL tie2_order: got ok %b%b n %0d first %b last %b required 11 4 %b %b",
                  ok_w, ok_r, n_starts, log_write[0], log_write[3], first_exp, !first_exp);
      end
   endtask

   task automatic test_write_wrap();
      logic [1:0] resp;
      bit ok;
      clear_log();
      do_write(mk_desc(32'h500, 4'd2, BURST_WRAP), 32'hE0, resp, ok);
      n_tests++;
      if (!ok || n_whs !== 3 || n_starts !== 0) begin
         n_fail++;
         $display("FAIL wwrap_beats: got ok %b hs %0d starts %0d required 1 3 0", ok, n_whs,
                  n_starts);
      end
      n_tests++;
      if (resp !== RESP_SLVERR || n_wdone !== 1) begin
         n_fail++;
         $display("FAIL wwrap_resp: got resp %b dones %0d required 10 1", resp, n_wdone);
      end
   endtask

   task automatic test_read_stall();
      bit ok;
      clear_log();
      stall_bad = 0;
      rsp_data[0] = 32'h11;
      rsp_data[1] = 32'h22;
      do_read(mk_desc(32'hFFFF_FFFC, 4'd1, BURST_INCR), 0, 5, ok);
      n_tests++;
      if (!ok || n_starts !== 2 || log_addr[0] !== 32'hFFFF_FFFC || log_addr[1] !== 32'h0) begin
         n_fail++;
         $display("FAIL rstall_addr: got ok %b n %0d addr %h %h required 1 2 fffffffc 0", ok,
                  n_starts, log_addr[0], log_addr[1]);
      end
      n_tests++;
      if (stall_bad !== 0 || stall_s0 !== 1 || stall_s1 !== 1) begin
         n_fail++;
         $display("FAIL rstall_hold: got unstable %0d starts %0d->%0d required 0 1->1",
                  stall_bad, stall_s0, stall_s1);
      end
      n_tests++;
      if (got_data[0] !== 32'h11 || got_last[0] !== 1'b0 || got_data[1] !== 32'h22 ||
          got_last[1] !== 1'b1 || got_resp[1] !== RESP_OKAY) begin
         n_fail++;
         $display("FAIL rstall_data: got %h/%b %h/%b/%b required 11/0 22/1/00", got_data[0],
                  got_last[0], got_data[1], got_last[1], got_resp[1]);
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [1:0] resp;
      bit ok_w;
      bit ok_r;
      int k;
      clear_log();
      bus.wr_desc = mk_desc(32'h2000, 4'd3, BURST_INCR);
      bus.wr_req  = 1'b1;
      for (int b = 0; b < 3; b++) begin
         bus.wr_data   = 32'hF0 + 32'(b);
         bus.wr_dvalid = 1'b1;
         for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.wr_dready) break;
         end
         @(posedge clk);
         #1;
         bus.wr_dvalid = 1'b0;
      end
      for (k = 0; k < 300; k++) begin
         @(negedge clk);
         if (n_starts == 3) break;
      end
      n_tests++;
      if (n_starts !== 3 || bus.apb_addr !== 32'h2008) begin
         n_fail++;
         $display("FAIL rmid_reach: got starts %0d addr %h required 3 2008", n_starts,
                  bus.apb_addr);
      end
      rst_n = 1'b0;
      bus.wr_req = 1'b0;
      #1;
      n_tests++;
      if ({bus.wr_dready, bus.wr_done, bus.rd_dvalid, bus.apb_start, bus.apb_write} !== 5'b0 ||
          bus.apb_addr !== 32'h0 || bus.apb_wdata !== 32'h0) begin
         n_fail++;
         $display("FAIL rmid_outputs: got ctl %b addr %h wdata %h required 0 0 0",
                  {bus.wr_dready, bus.wr_done, bus.rd_dvalid, bus.apb_start, bus.apb_write},
                  bus.apb_addr, bus.apb_wdata);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      clear_log();
      rsp_data[0] = 32'h77;
      do_read(mk_desc(32'h3000, 4'd0, BURST_INCR), -1, 0, ok_r);
      n_tests++;
      if (!ok_r || n_starts !== 1 || log_addr[0] !== 32'h3000 || got_data[0] !== 32'h77 ||
          got_resp[0] !== RESP_OKAY || got_last[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL rmid_read: got ok %b n %0d addr %h data %h resp %b last %b required 1 1 3000 77 00 1",
                  ok_r, n_starts, log_addr[0], got_data[0], got_resp[0], got_last[0]);
      end
      clear_log();
      fork
         do_write(mk_desc(32'h3100, 4'd0, BURST_INCR), 32'h90, resp, ok_w);
         do_read(mk_desc(32'h3200, 4'd0, BURST_INCR), -1, 0, ok_r);
      join
      n_tests++;
      if (!ok_w || !ok_r || n_starts !== 2 || log_write[0] !== 1'b1 ||
          log_addr[0] !== 32'h3100) begin
         n_fail++;
         $display("FAIL rmid_tie: got ok %b%b n %0d first wr %b addr %h required 11 2 1 3100",
                  ok_w, ok_r, n_starts, log_write[0], log_addr[0]);
      end
   endtask

   initial begin
      test_reset();
      test_write_incr();
      test_read_fixed();
      test_tie();
      test_write_wrap();
      test_read_stall();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
